// File: rtl/dev_bus_bridge.sv
// Memory-stage bus bridge: zero-wait data-memory pass-through plus a req/ack
// sequencer with timeout for the two device register windows.
module dev_bus_bridge #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
  parameter int unsigned DEV_SPAN  = 12,
  parameter logic [31:0] DATA_END  = 32'h0000_2FFF,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        PrWE,
  input  logic        PrRE,
  input  logic [3:0]  PrBE,
  output logic [31:0] PrRD,
  output logic        PrStall,
  output logic        PrBusErr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rd,
  output logic [1:0]  dev_sel,
  output logic [3:0]  dev_addr,
  output logic [31:0] dev_wd,
  output logic        dev_we,
  output logic        dev_req,
  input  logic [1:0]  dev_ack,
  input  logic [31:0] dev_rd0,
  input  logic [31:0] dev_rd1
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      rd_q, rd_nxt;
  logic [1:0]       sel_q, sel_nxt;
  logic [3:0]       addr_q, addr_nxt;
  logic [31:0]      wd_q, wd_nxt;
  logic             we_q, we_nxt;

  logic mem_hit, dev0_hit, dev1_hit, dev_hit, act, ack_sel, start;

  // Address decode; window ends are computed in 33 bits so they cannot wrap.
  assign mem_hit  = (PrAddr <= DATA_END);
  assign dev0_hit = (PrAddr >= DEV0_BASE) &&
                    ({1'b0, PrAddr} < ({1'b0, DEV0_BASE} + 33'(DEV_SPAN)));
  assign dev1_hit = (PrAddr >= DEV1_BASE) &&
                    ({1'b0, PrAddr} < ({1'b0, DEV1_BASE} + 33'(DEV_SPAN)));
  assign dev_hit  = dev0_hit | dev1_hit;
  assign act      = PrWE | PrRE;
  assign start    = (state == S_IDLE) & act & dev_hit;
  assign ack_sel  = |(dev_ack & sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rd_q   <= '0;
      sel_q  <= '0;
      addr_q <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rd_q   <= rd_nxt;
      sel_q  <= sel_nxt;
      addr_q <= addr_nxt;
      wd_q   <= wd_nxt;
      we_q   <= we_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = rd_q;
    sel_nxt   = sel_q;
    addr_nxt  = addr_q;
    wd_nxt    = wd_q;
    we_nxt    = we_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_REQ;
          cnt_nxt   = '0;
          sel_nxt   = {dev1_hit & ~dev0_hit, dev0_hit};
          addr_nxt  = PrAddr[3:0];
          wd_nxt    = PrWD;
          we_nxt    = PrWE;
        end
      end
      S_REQ: begin
        // An ack arriving in the timeout cycle still completes the access.
        if (ack_sel) begin
          if (!we_q) rd_nxt = sel_q[0] ? dev_rd0 : dev_rd1;
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dm_addr = PrAddr;
  assign dm_wd   = PrWD;
  assign dm_be   = PrBE;
  assign dm_we   = PrWE & mem_hit & (state == S_IDLE);

  assign dev_req  = (state == S_REQ);
  assign dev_sel  = dev_req ? sel_q : 2'b00;
  assign dev_we   = dev_req & we_q;
  assign dev_addr = addr_q;
  assign dev_wd   = wd_q;

  assign PrStall  = rst_n & (start | (state == S_REQ));
  assign PrBusErr = (state == S_ERR);

  always_comb begin
    PrRD = 32'h0;
    case (state)
      S_DONE:  PrRD = rd_q;
      S_ERR:   PrRD = 32'h0;
      default: PrRD = mem_hit ? dm_rd : 32'h0;
    endcase
  end

endmodule
